alu_rotate_seq: RTL and testbench
=================================

Name: alu_rotate_seq

Overview:
Multi-cycle, parametrised rotate engine. It is the sequential successor to the combinational ROL/ROR/RCL/RCR path in alu_advanced. Operands arrive through a valid/ready handshake and are rotated STEP bit positions per cycle through a WIDTH-bit (or WIDTH+1-bit, through carry) register. The result returns with {V,C,N,Z} flags on an output valid/ready handshake, so a pipelined datapath can share one rotator under backpressure.

Parameters:
- WIDTH, 32, operand width; power of two, 8 to 64.
- STEP, 4, bit positions rotated per RUN cycle; power of two, 1 to WIDTH.
- AW, $clog2(WIDTH), rotate-amount width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_a  in  WIDTH  operand to rotate.
- in_amt  in  AW  rotate amount, 0 to WIDTH-1.
- in_op  in  2  operation: 00 ROL, 01 ROR, 10 RCL, 11 RCR. This equals ALU Opcode minus 5'b01011.
- in_cin  in  1  carry-in for RCL/RCR; also C when amount is 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  rotated value.
- out_flags  out  4  {V,C,N,Z}.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. out_valid=0, out_result=0, out_flags=0, in_ready=1. Any in-flight operation is discarded and produces no output.
- in_ready = (state==IDLE), decoded combinationally from state.
- States:
  - IDLE: on in_valid&&in_ready, latch a, amt, op, cin into a working register `rem` (the remaining count). Go to RUN if amt!=0, else go to DONE.
  - RUN: each cycle rotate by k=min(STEP,rem) and set rem-=k. When rem reaches 0, go to DONE on the next edge.
  - DONE: out_valid=1. out_result and out_flags are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Latency from accept edge to out_valid high = 1 + ceil(amt/STEP) cycles. amt=0 gives 1 cycle.
- No new request is accepted while in RUN or DONE. in_valid in those states is ignored and is not latched.
- A request and a result cannot complete on the same edge, because in_ready is 0 in DONE.
- ROL/ROR: plain WIDTH-bit rotate; in_cin is not used for the data.
- RCL/RCR: rotate over the WIDTH+1-bit vector {C, data}, with C initialised from in_cin.
- C flag:
  - ROL: C = result[0].
  - ROR: C = result[WIDTH-1].
  - RCL/RCR: C = final carry bit.
  - amt=0: C = in_cin and result = in_a.
- V flag is defined only for amt==1:
  - ROL/RCL: V = result[WIDTH-1]^C.
  - ROR/RCR: V = result[WIDTH-1]^result[WIDTH-2].
  - V=0 for any other amount.
- N = result[WIDTH-1]. Z = (result==0).
- Flags are registered together with out_result on entry to DONE.
- in_amt is strictly AW bits wide, so amounts of WIDTH or more are not representable. RCL/RCR by WIDTH (a full cycle through the carry) cannot occur.

Optional Feature:
ALU_ROT_FAST_EN
- Defined: a full barrel rotator is used instead of the iterative engine. RUN is never entered; IDLE always goes to DONE. Latency is 1 cycle for every amt. STEP is ignored. Results and flags are identical to the iterative build.
- Undefined: iterative engine with the latency formula above.

Test Plan (WIDTH=32, STEP=4, flags shown as {V,C,N,Z}):
1. ROL, a=0x80000001, amt=1 -> result 0x00000003, flags 1100. out_valid rises 2 cycles after accept.
2. ROR, a=0x00000001, amt=1 -> result 0x80000000, flags 1110. Then RCR, a=0x00000000, cin=1, amt=1 -> result 0x80000000, flags 1010.
3. RCL:
   - a=0x80000000, cin=0, amt=1 -> result 0x00000000, flags 1101.
   - a=0x00000000, cin=1, amt=1 -> result 0x00000001, flags 0000.
   - RCR a=0x00000001, cin=0, amt=1 -> result 0x00000000, flags 0101.
4. Amount boundaries:
   - ROL, a=0x12345678, cin=1, amt=0 -> result 0x12345678, flags 0100, out_valid 1 cycle after accept.
   - ROL, a=0x00000001, amt=31 -> result 0x80000000, flags 0010, out_valid 9 cycles after accept.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result and out_flags stable, in_ready=0. A second in_valid pulse during those cycles is not accepted. out_ready=1 -> next cycle in_ready=1.
6. Assert rst_n=0 in the third RUN cycle of ROL amt=31 -> out_valid=0 and in_ready=1 immediately. After release, a new ROL a=0x1, amt=4 completes with 0x00000010 and flags 0000.

Source files
------------

// File: rtl/alu_rotate_seq.sv
// alu_rotate_seq: multi-cycle rotate engine (ROL/ROR/RCL/RCR) with
// valid/ready handshakes on both sides and {V,C,N,Z} result flags.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (in_ready high only in IDLE)
//   in_a, in_amt, in_op  operand, rotate amount (0..WIDTH-1), operation
//                        00 ROL, 01 ROR, 10 RCL, 11 RCR
//   in_cin               carry-in for RCL/RCR; reported as C when amt==0
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   out_result           rotated value, held until out_ready
//   out_flags            {V,C,N,Z}, held with out_result
//
// Build option: define ALU_ROT_FAST_EN to replace the iterative engine with
// a single-cycle barrel rotator (RUN is never entered, STEP is ignored).
//
// state | meaning
// IDLE  | ready for a request
// RUN   | rotating up to STEP positions per cycle, r_rem positions left
// DONE  | result and flags presented, waiting for out_ready
module alu_rotate_seq #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    // Rotate {c,data} by n positions; returns {carry, data}. ROL/ROR leave the
    // carry untouched, RCL/RCR rotate through it as a WIDTH+1-bit vector.
    function automatic logic [WIDTH:0] rot_n(input logic [1:0] op,
                                             input logic [WIDTH-1:0] data,
                                             input logic c, input int n);
        logic [2*WIDTH-1:0] w2;
        logic [2*WIDTH+1:0] w3;
        logic [WIDTH:0]     res;
        w2  = '0;
        w3  = '0;
        res = {c, data};
        case (op)
            2'b00: begin w2 = {data, data} << n; res = {c, w2[2*WIDTH-1:WIDTH]}; end
            2'b01: begin w2 = {data, data} >> n; res = {c, w2[WIDTH-1:0]}; end
            2'b10: begin w3 = {c, data, c, data} << n; res = w3[2*WIDTH+1:WIDTH+1]; end
            default: begin w3 = {c, data, c, data} >> n; res = w3[WIDTH:0]; end
        endcase
        return res;
    endfunction

    function automatic logic [3:0] calc_flags(input logic [1:0] op,
                                              input logic [WIDTH-1:0] res,
                                              input logic carry, input logic is1,
                                              input logic is0, input logic cin);
        logic c;
        logic v;
        if (is0)        c = cin;
        else if (op[1]) c = carry;
        else if (op[0]) c = res[WIDTH-1];
        else            c = res[0];
        // V only has meaning for single-position rotates.
        if (!is1)       v = 1'b0;
        else if (op[0]) v = res[WIDTH-1] ^ res[WIDTH-2];
        else            v = res[WIDTH-1] ^ c;
        return {v, c, res[WIDTH-1], (res == '0)};
    endfunction

`ifdef ALU_ROT_FAST_EN
    logic [WIDTH:0] w_fast;

    // Log-depth barrel: stage s rotates by 2^s when amount bit s is set.
    always_comb begin
        w_fast = {in_cin, in_a};
        for (int s = 0; s < AW; s++) begin
            if (in_amt[s]) w_fast = rot_n(in_op, w_fast[WIDTH-1:0], w_fast[WIDTH], 1 << s);
        end
    end
`else
    logic [WIDTH-1:0] r_data;
    logic             r_c;
    logic [AW-1:0]    r_rem;
    logic [1:0]       r_op;
    logic             r_amt1;
    logic [WIDTH:0]   w_step;
    logic             w_last;

    // Up to STEP single-position rotates, only as many as remain.
    always_comb begin
        w_step = {r_c, r_data};
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(r_rem)) w_step = rot_n(r_op, w_step[WIDTH-1:0], w_step[WIDTH], 1);
        end
    end

    // The final RUN cycle writes the result and enters DONE on the same edge.
    assign w_last = (int'(r_rem) <= STEP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
`ifdef ALU_ROT_FAST_EN
                if (in_valid) w_state_nxt = DONE;
`else
                if (in_valid) w_state_nxt = (in_amt == '0) ? DONE : RUN;
`endif
            end
            RUN: begin
`ifdef ALU_ROT_FAST_EN
                w_state_nxt = IDLE;
`else
                if (w_last) w_state_nxt = DONE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
`ifndef ALU_ROT_FAST_EN
            r_data   <= '0;
            r_c      <= 1'b0;
            r_rem    <= '0;
            r_op     <= 2'b00;
            r_amt1   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_ROT_FAST_EN
                        r_result <= w_fast[WIDTH-1:0];
                        r_flags  <= calc_flags(in_op, w_fast[WIDTH-1:0], w_fast[WIDTH],
                                               (in_amt == AW'(1)), (in_amt == '0), in_cin);
`else
                        r_data <= in_a;
                        r_c    <= in_cin;
                        r_rem  <= in_amt;
                        r_op   <= in_op;
                        r_amt1 <= (in_amt == AW'(1));
                        if (in_amt == '0) begin
                            r_result <= in_a;
                            r_flags  <= calc_flags(in_op, in_a, in_cin, 1'b0, 1'b1, in_cin);
                        end
`endif
                    end
                end
`ifndef ALU_ROT_FAST_EN
                RUN: begin
                    r_data <= w_step[WIDTH-1:0];
                    r_c    <= w_step[WIDTH];
                    if (w_last) begin
                        r_rem    <= '0;
                        r_result <= w_step[WIDTH-1:0];
                        r_flags  <= calc_flags(r_op, w_step[WIDTH-1:0], w_step[WIDTH],
                                               r_amt1, 1'b0, r_c);
                    end else begin
                        r_rem <= r_rem - AW'(STEP);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign out_result = r_result;
    assign out_flags  = r_flags;

endmodule

// File: tb/tb_alu_rotate_seq.sv
module tb_alu_rotate_seq;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int AW    = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [AW-1:0]    in_amt;
    logic [1:0]       in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_rotate_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: rotation as modular arithmetic on a 32- or 33-bit value.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic cin,
                                  input int amt, output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua, v, x, y;
        logic c, ov;
        ua = longint'(a);
        v  = (longint'(cin) << 32) | ua;
        y  = 0;
        case (op)
            2'd0: x = ((ua << amt) | (ua >> (32 - amt))) & 64'hFFFF_FFFF;
            2'd1: x = ((ua >> amt) | (ua << (32 - amt))) & 64'hFFFF_FFFF;
            2'd2: begin
                y = ((v << amt) | (v >> (33 - amt))) & 64'h1_FFFF_FFFF;
                x = y & 64'hFFFF_FFFF;
            end
            default: begin
                y = ((v >> amt) | (v << (33 - amt))) & 64'h1_FFFF_FFFF;
                x = y & 64'hFFFF_FFFF;
            end
        endcase
        if (amt == 0)     c = cin;
        else if (op == 0) c = x[0];
        else if (op == 1) c = x[31];
        else              c = y[32];
        if (amt != 1)                 ov = 1'b0;
        else if (op == 0 || op == 2)  ov = x[31] ^ c;
        else                          ov = x[31] ^ x[30];
        r = x[31:0];
        f = {ov, c, x[31], (x[31:0] == 0)};
    endfunction

    // Issue one request, measure latency, check against the model, then
    // release the result after 'stall' extra cycles of backpressure.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic cin, input int amt, input int stall,
                         output logic [31:0] got_r, output logic [3:0] got_f);
        logic [31:0] er;
        logic [3:0]  ef;
        int cyc, exp_lat;
        model(op, a, cin, amt, er, ef);
`ifdef ALU_ROT_FAST_EN
        exp_lat = 1;
`else
        exp_lat = 1 + (amt + STEP - 1) / STEP;
`endif
        @(negedge clk);
        chk({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; in_op = op; in_a = a; in_cin = cin; in_amt = AW'(amt);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_res"}, out_result, er);
        chk({tag, "_flg"}, out_flags, ef);
        got_r = out_result;
        got_f = out_flags;
        repeat (stall) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, in_ready, 1'b1);
    endtask

    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] hold_r;
    logic [3:0]  hold_f;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_amt = '0; in_op = 2'b00;
        in_cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_res", out_result, 32'h0);
        chk("rst_flg", out_flags, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with literal expected values.
        do_op("rol1", 2'd0, 32'h8000_0001, 1'b0, 1, 0, r, f);
        chk("rol1_lit", {r, f}, {32'h0000_0003, 4'b1100});
        do_op("ror1", 2'd1, 32'h0000_0001, 1'b0, 1, 0, r, f);
        chk("ror1_lit", {r, f}, {32'h8000_0000, 4'b1110});
        do_op("rcr1", 2'd3, 32'h0000_0000, 1'b1, 1, 0, r, f);
        chk("rcr1_lit", {r, f}, {32'h8000_0000, 4'b1010});
        do_op("rcl1a", 2'd2, 32'h8000_0000, 1'b0, 1, 0, r, f);
        chk("rcl1a_lit", {r, f}, {32'h0000_0000, 4'b1101});
        do_op("rcl1b", 2'd2, 32'h0000_0000, 1'b1, 1, 0, r, f);
        chk("rcl1b_lit", {r, f}, {32'h0000_0001, 4'b0000});
        do_op("rcr1b", 2'd3, 32'h0000_0001, 1'b0, 1, 0, r, f);
        chk("rcr1b_lit", {r, f}, {32'h0000_0000, 4'b0101});
        do_op("rol0", 2'd0, 32'h1234_5678, 1'b1, 0, 0, r, f);
        chk("rol0_lit", {r, f}, {32'h1234_5678, 4'b0100});
        do_op("rol31", 2'd0, 32'h0000_0001, 1'b0, 31, 0, r, f);
        chk("rol31_lit", {r, f}, {32'h8000_0000, 4'b0010});

        // Backpressure: result held, second request ignored.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1; in_a = 32'hA5A5_0F0F; in_cin = 1'b1; in_amt = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", out_valid, 1'b1);
        hold_r = out_result;
        hold_f = out_flags;
        model(2'd1, 32'hA5A5_0F0F, 1'b1, 9, r, f);
        chk("bp_res", hold_r, r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            in_a = 32'hFFFF_FFFF; in_amt = 5'd0;
            @(posedge clk); #1;
            chk("bp_hold_res", out_result, hold_r);
            chk("bp_hold_flg", out_flags, hold_f);
            chk("bp_ready0", in_ready, 1'b0);
            chk("bp_valid1", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_ready1", in_ready, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_no_accept", out_valid, 1'b0);
        end

        // Reset in the third RUN cycle of ROL by 31.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'h1; in_cin = 1'b0; in_amt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 2'd0, 32'h1, 1'b0, 4, 0, r, f);
        chk("post_rst_lit", {r, f}, {32'h0000_0010, 4'b0000});

        // Randomized operations, amount boundaries mixed in.
        for (int i = 0; i < 60; i++) begin
            int amt;
            case (i % 6)
                0: amt = 0;
                1: amt = 31;
                2: amt = STEP;
                3: amt = STEP + 1;
                default: amt = $urandom_range(0, 31);
            endcase
            do_op("rnd", 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                  amt, $urandom_range(0, 2), r, f);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
